// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the keypad scanner: FSM encoding, matrix size
// and key-matrix decode functions.
package keypad_scanner_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LOCKED  = 2'd2
  } kp_state_e;

  function automatic logic [4:0] key_count(input logic [NUM_KEYS-1:0] m);
    logic [4:0] n;
    n = '0;
    for (int b = 0; b < NUM_KEYS; b++) n = n + {4'd0, m[b]};
    return n;
  endfunction

  // Matrix bit index is col*4+row; the reported code is row*4+col.
  function automatic logic [3:0] key_code(input logic [NUM_KEYS-1:0] m);
    logic [3:0] code;
    logic [3:0] bi;
    code = '0;
    for (int b = 0; b < NUM_KEYS; b++) begin
      bi = 4'(b);
      if (m[b]) code = {bi[1:0], bi[3:2]};
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Board-side keypad signal bundle: row sense in, column drive and key report out.
interface keypad_scanner_if;
  logic [3:0] keyRow;
  logic [3:0] keyCol;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyHeld;

  modport master (output keyRow, input keyCol, keyCode, keyValid, keyHeld);
  modport slave  (input keyRow, output keyCol, keyCode, keyValid, keyHeld);
endinterface

// File: rtl/keypad_debounce.sv
// Whole-matrix debouncer: a snapshot must repeat DEBOUNCE times before it is
// accepted; acceptance is signalled by a one-cycle update strobe.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] snap_i,
  input  logic                frame_end_i,
  output logic [NUM_KEYS-1:0] deb_o,
  output logic                upd_o
);

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [NUM_KEYS-1:0] prev_q;
  logic [NUM_KEYS-1:0] deb_q;
  logic [3:0]          cnt_q, cnt_d;
  logic                upd_q;
  logic                load;

  always_comb begin
    cnt_d = cnt_q;
    if (frame_end_i) begin
      if (snap_i == prev_q) cnt_d = (cnt_q == DB) ? cnt_q : cnt_q + 4'd1;
      else                  cnt_d = '0;
    end
    // Load only on the transition into DB so a held pattern is accepted once.
    load = frame_end_i && (cnt_d == DB) && (cnt_q != DB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      upd_q <= load;
      if (frame_end_i) prev_q <= snap_i;
      if (load)        deb_q  <= snap_i;
    end
  end

  assign deb_o = deb_q;
  assign upd_o = upd_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: one-hot column drive, synchronised row sense,
// frame snapshots, debounce and single-key report FSM.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.slave  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]    dwell_q, dwell_d;
  logic [1:0]          col_q, col_d;
  logic [NUM_COLS-1:0] col_oh_q, col_oh_d;
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic                term, frame_end;

  logic [NUM_KEYS-1:0] deb;
  logic                upd;
  logic [4:0]          deb_cnt;
  logic [3:0]          deb_code;

  kp_state_e           state_q;
  logic [3:0]          code_q;
  logic                valid_q, held_q;

  always_comb begin
    term     = (dwell_q == DIV_W'(SCAN_DIV - 1));
    dwell_d  = term ? '0 : dwell_q + DIV_W'(1);
    col_d    = term ? col_q + 2'd1 : col_q;
    col_oh_d = 4'b0001 << col_d;
    snap_d   = snap_q;
    // Rows are taken on the last dwell cycle so the synchroniser has settled.
    if (term) snap_d[{col_q, 2'b00} +: NUM_ROWS] = row_s2_q;
    frame_end = term && (col_q == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q <= '0;
      row_s2_q <= '0;
      dwell_q  <= '0;
      col_q    <= '0;
      col_oh_q <= 4'b0001;
      snap_q   <= '0;
    end else begin
      row_s1_q <= kp.keyRow;
      row_s2_q <= row_s1_q;
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      col_oh_q <= col_oh_d;
      snap_q   <= snap_d;
    end
  end

  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .snap_i      (snap_d),
    .frame_end_i (frame_end),
    .deb_o       (deb),
    .upd_o       (upd)
  );

  assign deb_cnt  = key_count(deb);
  assign deb_code = key_code(deb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (upd) begin
        unique case (state_q)
          IDLE: begin
            if (deb_cnt == 5'd1) begin
              state_q <= PRESSED;
              code_q  <= deb_code;
              valid_q <= 1'b1;
              held_q  <= 1'b1;
            end else if (deb_cnt != 5'd0) begin
              state_q <= LOCKED;
            end
          end
          PRESSED: begin
            if (deb_cnt == 5'd0) begin
              state_q <= IDLE;
              held_q  <= 1'b0;
            end else if (deb_cnt != 5'd1 || deb_code != code_q) begin
              // Rollover to another key requires a full release first.
              state_q <= LOCKED;
              held_q  <= 1'b0;
            end
          end
          LOCKED: begin
            if (deb_cnt == 5'd0) state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign kp.keyCol   = col_oh_q;
  assign kp.keyCode  = code_q;
  assign kp.keyValid = valid_q;
  assign kp.keyHeld  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames);
// the key matrix is modelled combinationally from keyCol and the pressed set.
module tb_keypad_scanner;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;   // indexed by key code row*4+col
  logic [3:0]  row_drv;

  int tests = 0;
  int fails = 0;

  int       pulse_cnt  = 0;
  int       consec_cnt = 0;
  int       held_cyc   = 0;
  logic     prev_valid = 1'b0;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) row_drv[r] = |(pressed[r*4 +: 4] & kif.keyCol);
  end
  assign kif.keyRow = row_drv;

  always @(negedge clk) begin
    if (kif.keyValid === 1'b1) pulse_cnt++;
    if (kif.keyValid === 1'b1 && prev_valid === 1'b1) consec_cnt++;
    prev_valid = kif.keyValid;
    if (kif.keyHeld === 1'b1) held_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int bound, output logic found);
    found = 1'b0;
    for (int k = 0; k < bound && !found; k++) begin
      @(negedge clk);
      if (kif.keyValid === 1'b1) found = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic       found;
    logic [3:0] exp_col;
    int         p0, h0;

    // 1. Reset state and column scan
    repeat (3) @(negedge clk);
    chk("rst_keyCol",   kif.keyCol,   4'b0001);
    chk("rst_keyCode",  kif.keyCode,  4'h0);
    chk("rst_keyValid", kif.keyValid, 1'b0);
    chk("rst_keyHeld",  kif.keyHeld,  1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp_col = 4'b0001 << (i % 4);
        chk("scan_keyCol", kif.keyCol, exp_col);
        @(negedge clk);
      end
    end
    wait_frames(3);
    chk("idle_pulses", pulse_cnt, 0);
    chk("idle_held",   held_cyc,  0);

    // 2. Single press row 2 / col 1
    p0 = pulse_cnt;
    pressed[9] = 1'b1;
    wait_pulse(70, found);
    chk("t2_found",   found,        1'b1);
    chk("t2_keyCode", kif.keyCode,  4'h9);
    chk("t2_held_at", kif.keyHeld,  1'b1);
    wait_frames(3);
    chk("t2_held",    kif.keyHeld,  1'b1);
    chk("t2_pulses",  pulse_cnt - p0, 1);
    pressed = '0;
    wait_frames(5);
    chk("t2_release_held", kif.keyHeld, 1'b0);
    chk("t2_pulses_after", pulse_cnt - p0, 1);
    chk("t2_code_holds",   kif.keyCode, 4'h9);

    // 3. Bounce: key 0x3 for one frame only
    p0 = pulse_cnt;
    h0 = held_cyc;
    pressed[3] = 1'b1;
    repeat (FRAME) @(negedge clk);
    pressed = '0;
    wait_frames(5);
    chk("t3_pulses", pulse_cnt - p0, 0);
    chk("t3_held",   held_cyc - h0,  0);

    // 4. Multi-key and rollover
    pressed[5] = 1'b1;
    wait_pulse(70, found);
    chk("t4_found5",  found,       1'b1);
    chk("t4_code5",   kif.keyCode, 4'h5);
    p0 = pulse_cnt;
    pressed[10] = 1'b1;
    wait_frames(5);
    chk("t4_lock_held",   kif.keyHeld,    1'b0);
    chk("t4_lock_pulses", pulse_cnt - p0, 0);
    h0 = held_cyc;
    pressed[5] = 1'b0;
    wait_frames(5);
    chk("t4_roll_held",   held_cyc - h0,  0);
    chk("t4_roll_pulses", pulse_cnt - p0, 0);
    chk("t4_roll_code",   kif.keyCode,    4'h5);
    pressed = '0;
    wait_frames(5);
    pressed[10] = 1'b1;
    wait_pulse(70, found);
    chk("t4_foundA", found,       1'b1);
    chk("t4_codeA",  kif.keyCode, 4'hA);
    pressed = '0;
    wait_frames(5);

    // 5. Reset mid-press
    pressed[3] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (kif.keyHeld === 1'b1) found = 1'b1;
    end
    chk("t5_held_seen", found, 1'b1);
    chk("t5_code_pre",  kif.keyCode, 4'h3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_keyCol",   kif.keyCol,   4'b0001);
    chk("t5_rst_keyCode",  kif.keyCode,  4'h0);
    chk("t5_rst_keyValid", kif.keyValid, 1'b0);
    chk("t5_rst_keyHeld",  kif.keyHeld,  1'b0);
    #9 rst = 1'b0;
    wait_pulse(80, found);
    chk("t5_found", found,       1'b1);
    chk("t5_code",  kif.keyCode, 4'h3);
    chk("t5_held",  kif.keyHeld, 1'b1);
    pressed = '0;
    wait_frames(5);

    // 6. Repeat press of 0xF
    p0 = pulse_cnt;
    pressed[15] = 1'b1;
    wait_pulse(70, found);
    chk("t6_found1", found,       1'b1);
    chk("t6_code1",  kif.keyCode, 4'hF);
    pressed = '0;
    wait_frames(5);
    chk("t6_rel_held", kif.keyHeld, 1'b0);
    pressed[15] = 1'b1;
    wait_pulse(70, found);
    chk("t6_found2", found,       1'b1);
    chk("t6_code2",  kif.keyCode, 4'hF);
    pressed = '0;
    wait_frames(5);
    chk("t6_pulses", pulse_cnt - p0, 2);

    chk("no_consecutive_valid", consec_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
